pe_sequencer: RTL and testbench
===============================

PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, neuron/weight address width; INST_AW, default 8, instruction-memory address width; RES_AW, default 8, result-memory address width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a run
- inst_num  in  INST_AW  number of instructions in the run; sampled on start
- inst_addr  out  INST_AW  instruction-memory read address
- inst_rd  out  1  instruction read strobe
- inst_data  in  8  iteration count; valid one cycle after inst_rd
- neuron_addr  out  ADDR_W  neuron buffer address
- weight_addr  out  ADDR_W  weight buffer address
- pe_vld_i  out  1  PE input valid
- pe_ctl  out  2  [0] first beat of a dot product; [1] last beat
- pe_vld_o  in  1  PE result valid
- pe_result  in  32  PE result
- res_we  out  1  result write enable
- res_addr  out  RES_AW  result write address
- res_data  out  32  result write data
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when the run completes
- err  out  1  sticky flag: unexpected result

Function
REQ-003 The FSM SHALL have five states: IDLE, FETCH, DECODE, ISSUE, DRAIN.
REQ-004 In IDLE, start with inst_num!=0 SHALL latch inst_num, clear both addresses, res_addr and the instruction index, and go to FETCH.
REQ-005 In IDLE, start with inst_num==0 SHALL pulse done on the next cycle and leave the block in IDLE.
REQ-006 FETCH SHALL assert inst_rd for one cycle at the current index; the next state SHALL be DECODE.
REQ-007 DECODE SHALL latch inst_data as the beat count N. If N==0 the instruction SHALL be skipped: no beats are issued and no result is expected.
REQ-008 ISSUE SHALL assert pe_vld_i for exactly N consecutive cycles.
- pe_ctl[0]=1 on beat 0 only; pe_ctl[1]=1 on beat N-1 only.
- N==1 gives pe_ctl=2'b11 on the single beat.
- pe_ctl SHALL be 0 whenever pe_vld_i=0.
REQ-009 neuron_addr and weight_addr SHALL increment by 1 after every issued beat and SHALL stay contiguous across instructions, with no reset between them. Wrap-around at 2^ADDR_W SHALL be modulo.
REQ-010 After the last beat, or after a skip in DECODE:
- if more instructions remain, the index increments and the next state is FETCH;
- otherwise the next state is DRAIN.
REQ-011 The outstanding counter (width INST_AW+1):
- +1 on each last beat;
- -1 on each pe_vld_o;
- unchanged when both happen in the same cycle.
REQ-012 Each pe_vld_o SHALL produce, in the next cycle: res_we=1, res_data=pe_result, and a write at res_addr. res_addr SHALL then increment and wrap modulo.
REQ-013 A pe_vld_o with outstanding==0 SHALL set err and SHALL NOT write a result. err SHALL clear only on reset or on an accepted start.
REQ-014 DRAIN SHALL wait for outstanding==0 and for the final result write. It SHALL then pulse done for one cycle and return to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE. start while busy SHALL be ignored.
REQ-016 Results SHALL be accepted in every state, including IDLE.

Reset
REQ-017 Reset SHALL force the following values:
- state IDLE;
- all counters and addresses 0;
- pe_vld_i, pe_ctl, inst_rd, res_we, busy, done and err all 0.
REQ-018 A reset asserted mid-ISSUE SHALL drop pe_vld_i immediately. After release, the block SHALL stay in IDLE until the next start.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding, the pe_ctl bit indices (CTL_FIRST=0, CTL_LAST=1) and the default widths.
REQ-020 A single sub-module, pe_seq_fsm, SHALL contain the state register and next-state logic. Counters and the result path SHALL remain in the top module.

Verification
REQ-021 Nominal run: counts {20,30,40,50}, PE model latency 3 -> 140 beats; addresses 0..139 contiguous; ctl[0] at beats 0,20,50,90; ctl[1] at beats 19,49,89,139; 4 writes at res_addr 0..3; one done pulse.
REQ-022 Single-beat and skip handling: counts {1,0,2} -> beat 0 has ctl=2'b11; the 0-count instruction issues nothing; 2 results written; done asserted.
REQ-023 Busy start: a second start during ISSUE is ignored, and the run completes exactly as in REQ-021.
REQ-024 Reset mid-run: rst_n low at beat 25 of REQ-021 -> all outputs 0 that cycle; after release, no beats until start; a fresh run starts at address 0.
REQ-025 Protocol errors: pe_vld_o injected in IDLE -> err=1, no res_we. start with inst_num=0 -> done pulse with no beats.

Source files
------------

// File: rtl/pe_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// pe_sequencer_pkg : FSM state encoding, pe_ctl bit indices, default widths
// Revision 1.0
// ============================================================================
package pe_sequencer_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INST_AW_DEF = 8;
    localparam int RES_AW_DEF  = 8;
    localparam int DATA_W      = 32;
    localparam int CNT_W       = 8;

    localparam int CTL_FIRST = 0;
    localparam int CTL_LAST  = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        ISSUE  = 3'd3,
        DRAIN  = 3'd4
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/pe_seq_fsm.sv
`default_nettype none
// ============================================================================
// pe_seq_fsm : run-control state register and next-state logic
// Revision 1.0
// ============================================================================
module pe_seq_fsm
    import pe_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       inst_num_zero,
    input  logic       skip,
    input  logic       last_beat,
    input  logic       more,
    input  logic       drain_ok,
    output seq_state_e state,
    output logic       run_start,
    output logic       done_set
);

    seq_state_e state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (inst_num_zero) begin
                        done_set = 1'b1;
                    end else begin
                        run_start = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                state_nxt = DECODE;
            end
            DECODE: begin
                if (skip) begin
                    state_nxt = more ? FETCH : DRAIN;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (last_beat) begin
                    state_nxt = more ? FETCH : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_ok) begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pe_sequencer.sv
`default_nettype none
// ============================================================================
// pe_sequencer : fetches beat counts, streams PE operands, collects results
// Revision 1.0
// ============================================================================
module pe_sequencer
    import pe_sequencer_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INST_AW = INST_AW_DEF,
    parameter int RES_AW  = RES_AW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [INST_AW-1:0] inst_num,
    output logic [INST_AW-1:0] inst_addr,
    output logic               inst_rd,
    input  logic [CNT_W-1:0]   inst_data,
    output logic [ADDR_W-1:0]  neuron_addr,
    output logic [ADDR_W-1:0]  weight_addr,
    output logic               pe_vld_i,
    output logic [1:0]         pe_ctl,
    input  logic               pe_vld_o,
    input  logic [DATA_W-1:0]  pe_result,
    output logic               res_we,
    output logic [RES_AW-1:0]  res_addr,
    output logic [DATA_W-1:0]  res_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    seq_state_e         state;
    logic               run_start;
    logic               done_set;

    logic [INST_AW-1:0] num;
    logic [INST_AW-1:0] idx;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   beat;
    logic [ADDR_W-1:0]  naddr;
    logic [ADDR_W-1:0]  waddr;
    logic [INST_AW:0]   outstanding;

    logic               in_issue;
    logic               skip;
    logic               last_beat;
    logic               more;
    logic               idx_adv;
    logic               result_ok;
    logic               result_bad;
    logic               idle_start;

    assign in_issue   = (state == ISSUE);
    assign skip       = (inst_data == '0);
    assign last_beat  = in_issue && (beat == beat_cnt - CNT_W'(1));
    assign more       = (idx != num - INST_AW'(1));
    assign idx_adv    = ((state == DECODE) && skip) || last_beat;
    assign result_ok  = pe_vld_o && (outstanding != '0);
    assign result_bad = pe_vld_o && (outstanding == '0);
    assign idle_start = (state == IDLE) && start;

    pe_seq_fsm u_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .inst_num_zero (inst_num == '0),
        .skip          (skip),
        .last_beat     (last_beat),
        .more          (more),
        .drain_ok      (outstanding == '0),
        .state         (state),
        .run_start     (run_start),
        .done_set      (done_set)
    );

    // Strobes decode straight from state so an async reset drops them at once.
    assign inst_addr         = idx;
    assign inst_rd           = (state == FETCH);
    assign pe_vld_i          = in_issue;
    assign pe_ctl[CTL_FIRST] = in_issue && (beat == '0);
    assign pe_ctl[CTL_LAST]  = last_beat;
    assign neuron_addr       = naddr;
    assign weight_addr       = waddr;
    assign busy              = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num      <= '0;
            idx      <= '0;
            naddr    <= '0;
            waddr    <= '0;
            beat_cnt <= '0;
            beat     <= '0;
        end else begin
            if (run_start) begin
                num   <= inst_num;
                idx   <= '0;
                naddr <= '0;
                waddr <= '0;
            end else begin
                if (idx_adv && more) begin
                    idx <= idx + INST_AW'(1);
                end
                if (in_issue) begin
                    naddr <= naddr + ADDR_W'(1);
                    waddr <= waddr + ADDR_W'(1);
                end
            end
            if (state == DECODE) begin
                beat_cnt <= inst_data;
                beat     <= '0;
            end else if (in_issue) begin
                beat <= beat + CNT_W'(1);
            end
        end
    end

    // One result is owed per issued dot product; a stray result never decrements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({last_beat, result_ok})
                2'b10:   outstanding <= outstanding + (INST_AW + 1)'(1);
                2'b01:   outstanding <= outstanding - (INST_AW + 1)'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_we   <= 1'b0;
            res_data <= '0;
            res_addr <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            res_we <= result_ok;
            if (result_ok) begin
                res_data <= pe_result;
            end
            if (run_start) begin
                res_addr <= '0;
            end else if (res_we) begin
                res_addr <= res_addr + RES_AW'(1);
            end
            if (result_bad) begin
                err <= 1'b1;
            end else if (idle_start) begin
                err <= 1'b0;
            end
            done <= done_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pe_sequencer : randomized self-checking bench with a PE model and scoreboard
// Revision 1.0
// ============================================================================
module tb_pe_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  inst_num;
    logic [7:0]  inst_addr;
    logic        inst_rd;
    logic [7:0]  inst_data;
    logic [15:0] neuron_addr;
    logic [15:0] weight_addr;
    logic        pe_vld_i;
    logic [1:0]  pe_ctl;
    logic        pe_vld_o;
    logic [31:0] pe_result;
    logic        res_we;
    logic [7:0]  res_addr;
    logic [31:0] res_data;
    logic        busy;
    logic        done;
    logic        err;

    pe_sequencer #(
        .ADDR_W  (16),
        .INST_AW (8),
        .RES_AW  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .inst_num    (inst_num),
        .inst_addr   (inst_addr),
        .inst_rd     (inst_rd),
        .inst_data   (inst_data),
        .neuron_addr (neuron_addr),
        .weight_addr (weight_addr),
        .pe_vld_i    (pe_vld_i),
        .pe_ctl      (pe_ctl),
        .pe_vld_o    (pe_vld_o),
        .pe_result   (pe_result),
        .res_we      (res_we),
        .res_addr    (res_addr),
        .res_data    (res_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  ctl;
    } beat_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          lat    = 3;
    int          wr_idx = 0;
    int          exp_nz = 0;
    int          obs_beats = 0;
    bit          inject = 0;
    logic [7:0]  mem [0:255];
    beat_t       beat_q [$];
    pend_t       pe_q [$];
    logic [31:0] wr_q [$];
    bit          rd_q = 0;
    logic [7:0]  rd_a = '0;
    logic [31:0] acc  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction memory, PE model and output scoreboard, all sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            beat_q.delete();
            pe_q.delete();
            wr_q.delete();
            pe_vld_o = 1'b0;
            rd_q     = 0;
            inject   = 0;
        end else begin
            inst_data = rd_q ? mem[rd_a] : 8'($urandom);
            rd_q      = inst_rd;
            rd_a      = inst_addr;

            if (pe_vld_i) begin
                beat_t       b;
                logic [31:0] term;
                obs_beats++;
                if (beat_q.size() == 0) begin
                    check("extra_beat", 32'(neuron_addr), 32'hFFFF_FFFF);
                end else begin
                    b = beat_q.pop_front();
                    check("neuron_addr", 32'(neuron_addr), 32'(b.addr));
                    check("weight_addr", 32'(weight_addr), 32'(b.addr));
                    check("pe_ctl", 32'(pe_ctl), 32'(b.ctl));
                end
                term = 32'(neuron_addr) * 32'(weight_addr) + 32'd1;
                acc  = pe_ctl[0] ? term : acc + term;
                if (pe_ctl[1]) pe_q.push_back('{due: cyc + lat, data: acc});
            end else begin
                check("ctl_idle", 32'(pe_ctl), 32'd0);
            end

            if (res_we) begin
                if (wr_q.size() == 0) begin
                    check("unexp_we", 32'(res_we), 32'd0);
                end else begin
                    check("res_data", res_data, wr_q.pop_front());
                    check("res_addr", 32'(res_addr), 32'(wr_idx[7:0]));
                    wr_idx++;
                end
            end

            pe_vld_o = 1'b0;
            if (pe_q.size() != 0 && pe_q[0].due <= cyc) begin
                pend_t p;
                p         = pe_q.pop_front();
                pe_vld_o  = 1'b1;
                pe_result = p.data;
                wr_q.push_back(p.data);
            end else if (inject) begin
                pe_vld_o  = 1'b1;
                pe_result = $urandom;
                inject    = 0;
            end
        end
        cyc++;
    end

    task automatic load(input int n, input int c0, input int c1, input int c2, input int c3);
        int c [4];
        c = '{c0, c1, c2, c3};
        for (int i = 0; i < n; i++) mem[i] = 8'(c[i]);
    endtask

    // Expected beat stream: one contiguous address run across all instructions.
    task automatic start_run(input int n);
        int base;
        base   = 0;
        exp_nz = 0;
        wr_idx = 0;
        beat_q.delete();
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < int'(mem[i]); k++) begin
                beat_t b;
                b.addr   = 16'(base + k);
                b.ctl[1] = (k == int'(mem[i]) - 1);
                b.ctl[0] = (k == 0);
                beat_q.push_back(b);
            end
            base += int'(mem[i]);
            if (mem[i] != 0) exp_nz++;
        end
        start    = 1'b1;
        inst_num = 8'(n);
        @(posedge clk); #1;
        start    = 1'b0;
        inst_num = 8'($urandom);
        check("busy_run", 32'(busy), 32'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("err_run", 32'(err), 32'd0);
        check("beats_left", 32'(beat_q.size()), 32'd0);
        check("writes_left", 32'(wr_q.size()), 32'd0);
        check("n_writes", 32'(wr_idx), 32'(exp_nz));
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
    endtask

    task automatic wait_addr(input int a);
        bit seen;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (pe_vld_i && neuron_addr == 16'(a)) begin
                seen = 1;
                break;
            end
        end
        check("reach_beat", 32'(seen), 32'd1);
    endtask

    task automatic check_zero();
        check("z_pe_vld_i", 32'(pe_vld_i), 32'd0);
        check("z_pe_ctl", 32'(pe_ctl), 32'd0);
        check("z_inst_rd", 32'(inst_rd), 32'd0);
        check("z_res_we", 32'(res_we), 32'd0);
        check("z_busy", 32'(busy), 32'd0);
        check("z_done", 32'(done), 32'd0);
        check("z_err", 32'(err), 32'd0);
        check("z_naddr", 32'(neuron_addr), 32'd0);
        check("z_waddr", 32'(weight_addr), 32'd0);
        check("z_res_addr", 32'(res_addr), 32'd0);
    endtask

    initial begin
        int beats_before;
        rst_n     = 1'b0;
        start     = 1'b0;
        inst_num  = '0;
        inst_data = '0;
        pe_vld_o  = 1'b0;
        pe_result = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal four-instruction run
        lat = 3;
        load(4, 20, 30, 40, 50);
        start_run(4);
        wait_done();

        // Single beat, skipped instruction, two beats
        load(3, 1, 0, 2, 0);
        start_run(3);
        wait_done();

        // Start while busy is ignored
        load(4, 20, 30, 40, 50);
        start_run(4);
        wait_addr(10);
        start    = 1'b1;
        inst_num = 8'd2;
        @(posedge clk); #1;
        start    = 1'b0;
        wait_done();

        // Reset in the middle of ISSUE
        load(4, 20, 30, 40, 50);
        start_run(4);
        wait_addr(25);
        rst_n = 1'b0;
        #1;
        check_zero();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("post_rst_vld", 32'(pe_vld_i), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
        start_run(4);
        wait_done();

        // Stray result in IDLE, then an empty run
        inject = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("err_stray", 32'(err), 32'd1);
        check("we_stray", 32'(res_we), 32'd0);
        beats_before = obs_beats;
        start    = 1'b1;
        inst_num = 8'd0;
        @(posedge clk); #1;
        start    = 1'b0;
        check("done_empty", 32'(done), 32'd1);
        check("busy_empty", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("done_empty_pulse", 32'(done), 32'd0);
        check("beats_empty", 32'(obs_beats), 32'(beats_before));

        // Randomized runs; the first accepted start must also clear err
        for (int r = 0; r < 8; r++) begin
            int n;
            n   = int'($urandom_range(1, 6));
            lat = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                mem[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            end
            start_run(n);
            wait_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
